sumador_serial_ctrl: RTL and testbench

SUMADOR_SERIAL_CTRL -- requirements
Module: sumador_serial_ctrl

---
 rtl/sumador_pkg.sv | 27 ++
 rtl/sumador1bit.sv | 26 ++
 rtl/sumador_serial_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sumador_serial_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// ----------------------------------------------------------------------------
// sumador_pkg
// Shared definitions for the bit-serial adder family.
//   n_default : default operand width used by sumador_serial_ctrl
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : width of the bit counter needed to count 0..n-1
// ----------------------------------------------------------------------------
package sumador_pkg;

   localparam int N_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A counter for 0..n-1 needs clog2(n) bits. The lower bound of one bit
   // keeps the counter a real vector even for degenerate widths.
   function automatic int cnt_width(input int n);
      if (n < 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sumador1bit.sv
// ----------------------------------------------------------------------------
// sumador1bit
// One-bit full adder, purely combinational.
//   a, b, cin : operand bits and incoming carry
//   sum       : a ^ b ^ cin
//   cout      : carry generated (a&b) or propagated (cin & (a^b))
// ----------------------------------------------------------------------------
module sumador1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Propagate term is shared between the sum and the carry chain.
   logic prop;

   // Classic generate/propagate formulation of the full adder.
   always_comb begin
      prop = a ^ b;
      sum  = prop ^ cin;
      cout = (a & b) | (cin & prop);
   end

endmodule

// File: rtl/sumador_serial_ctrl.sv
// ----------------------------------------------------------------------------
// sumador_serial_ctrl
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock through a
// single full adder. A request is taken in IDLE, RUN processes N bits LSB
// first, and DONE presents the result for exactly one cycle.
//
// Parameters
//   N     : operand width in bits (2..32)
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   start : request an addition (only looked at in IDLE)
//   a, b  : operands, captured together with start
//   cin   : carry-in, captured together with start
//   sum   : registered result of the last completed addition
//   cout  : registered carry-out of the last completed addition
//   busy  : high while the adder is in RUN
//   done  : one-cycle pulse when sum/cout have just been updated
// ----------------------------------------------------------------------------
module sumador_serial_ctrl
   import sumador_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         busy,
   output logic         done
);

   localparam int            CW       = cnt_width(N);
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   state_t          state_q;
   state_t          state_next;

   logic [N-1:0]    a_sr;
   logic [N-1:0]    b_sr;
   logic [N-2:0]    part_sr;
   logic [N-1:0]    part_wide;
   logic            carry_q;
   logic [CW-1:0]   cnt_q;

   logic            fa_sum;
   logic            fa_cout;

   logic            load;
   logic            step;
   logic            finish;

   // The only arithmetic in the design: one full adder fed by the LSBs of
   // the operand shift registers and the stored carry.
   sumador1bit u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // The partial result only needs N-1 stored bits: the N-th bit is the
   // adder output of the final RUN cycle. Concatenating the live adder bit
   // on top gives the full N-bit value both for shifting and for the final
   // load into sum, so every stored bit eventually reaches the output.
   assign part_wide = {fa_sum, part_sr};

   // Next-state and control decode. load marks the cycle a request is
   // accepted, step marks every RUN cycle, finish marks the last RUN cycle
   // (the one that produces the MSB and the final carry).
   always_comb begin
      state_next = state_q;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_q == LAST_BIT) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register plus the busy/done flags. The flags are registered from
   // the next state so they line up exactly with RUN and DONE without any
   // combinational path from the inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_next;
         busy    <= (state_next == RUN);
         done    <= (state_next == DONE);
      end
   end

   // Datapath registers. On accept the operands and carry are captured and
   // the counter cleared; afterwards the inputs are never looked at again,
   // so changes on a/b/cin during RUN cannot disturb the operation. Each RUN
   // cycle shifts the operands right, pushes the new sum bit in at the top
   // of the partial result and keeps the carry for the next bit. The counter
   // is cleared instead of incremented on the last bit so it never leaves
   // the range 0..N-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         part_sr <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (load) begin
         a_sr    <= a;
         b_sr    <= b;
         part_sr <= '0;
         carry_q <= cin;
         cnt_q   <= '0;
      end else if (step) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         part_sr <= part_wide[N-1:1];
         carry_q <= fa_cout;
         if (finish) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Result registers change only on the RUN->DONE edge, so the previous
   // result stays visible for the whole of the next operation. A reset in
   // the middle of RUN clears them and the partial work is simply lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (finish) begin
         sum  <= part_wide;
         cout <= fa_cout;
      end
   end

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sumador_serial_ctrl
// Scoreboard bench for the serial adder. Two instances share clock and
// reset: dut8 (N=8) for directed and random single operations, dut4 (N=4)
// for the exhaustive run with start held high. Expected results come from
// plain integer addition and are queued when a request is issued; monitors
// pop and compare whenever done is seen.
// ----------------------------------------------------------------------------
module tb_sumador_serial_ctrl;

   typedef struct {
      logic [8:0] res;
      int         k;
   } exp8_t;

   logic       clk;
   logic       rst_n;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       cin8;
   logic [7:0] sum8;
   logic       cout8;
   logic       busy8;
   logic       done8;

   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       cin4;
   logic [3:0] sum4;
   logic       cout4;
   logic       busy4;
   logic       done4;

   int         cyc;
   int         checks;
   int         passed;

   exp8_t      q8[$];
   logic [4:0] q4[$];

   int         busy8cnt;
   logic [8:0] last8;
   int         last_done4;
   bit         have_last4;

   sumador_serial_ctrl #(.N(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .sum   (sum8),
      .cout  (cout8),
      .busy  (busy8),
      .done  (done8)
   );

   sumador_serial_ctrl #(.N(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
      .sum   (sum4),
      .cout  (cout4),
      .busy  (busy4),
      .done  (done4)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter: after rising edge m, cyc holds m.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: the adder must behave like ordinary integer addition,
   // with the carry-out being bit N of the sum.
   function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
      int s;
      s = int'(x) + int'(y) + int'(c);
      return s[8:0];
   endfunction

   function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
      int s;
      s = (int'(x) + int'(y) + int'(c)) % 32;
      return s[4:0];
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request to dut8 for a single cycle, queue the expected result
   // and then scramble the operand inputs, which must no longer matter.
   task automatic applyStimulus8(input logic [7:0] x, input logic [7:0] y, input logic c);
      exp8_t e;
      a8     = x;
      b8     = y;
      cin8   = c;
      start8 = 1'b1;
      e.res  = model8(x, y, c);
      e.k    = cyc + 1;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      cin8   = 1'($urandom);
   endtask

   // Wait (bounded) for every queued dut8 result to be checked, then idle a
   // few cycles so a stray extra done would still be caught.
   task automatic drain8();
      for (int i = 0; i < 40 && q8.size() != 0; i++) begin
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      checkOutput("drain8", q8.size(), 0);
   endtask

   // dut8 monitor: result, latency (edges from the sampling edge to the edge
   // that first sees done), number of busy cycles, and sum/cout holding
   // their old value throughout RUN.
   always @(negedge clk) begin
      exp8_t e;
      if (!rst_n) begin
         busy8cnt = 0;
         last8    = '0;
      end else begin
         if (busy8) begin
            busy8cnt++;
            checkOutput("sum8_hold", int'({cout8, sum8}), int'(last8));
         end
         if (done8) begin
            if (q8.size() == 0) begin
               checkOutput("done8_unexpected", 1, 0);
            end else begin
               e = q8.pop_front();
               checkOutput("result8", int'({cout8, sum8}), int'(e.res));
               checkOutput("latency8", cyc + 1 - e.k, 9);
               checkOutput("busy8_cycles", busy8cnt, 8);
               last8 = e.res;
            end
            busy8cnt = 0;
         end
      end
   end

   // dut4 monitor: result and spacing between consecutive done pulses.
   always @(negedge clk) begin
      logic [4:0] r;
      if (rst_n && done4) begin
         if (q4.size() == 0) begin
            checkOutput("done4_unexpected", 1, 0);
         end else begin
            r = q4.pop_front();
            checkOutput("result4", int'({cout4, sum4}), int'(r));
         end
         if (have_last4) begin
            checkOutput("spacing4", cyc - last_done4, 6);
         end
         last_done4 = cyc;
         have_last4 = 1'b1;
      end
   end

   // Safety net in case the DUT never lets the stimulus make progress.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      logic [31:0] r;
      int          t;
      bit          stalled;

      checks     = 0;
      passed     = 0;
      busy8cnt   = 0;
      last8      = '0;
      last_done4 = 0;
      have_last4 = 1'b0;
      stalled    = 1'b0;

      rst_n  = 1'b0;
      start8 = 1'b0;
      a8     = 8'hA5;
      b8     = 8'h5A;
      cin8   = 1'b1;
      start4 = 1'b0;
      a4     = '0;
      b4     = '0;
      cin4   = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset_sum8", int'(sum8), 0);
      checkOutput("reset_cout8", int'(cout8), 0);
      checkOutput("reset_busy8", int'(busy8), 0);
      checkOutput("reset_done8", int'(done8), 0);
      checkOutput("reset_out4", int'({cout4, sum4, busy4, done4}), 0);
      rst_n = 1'b1;

      // Directed operations, including both wrap-around corners.
      applyStimulus8(8'h00, 8'h00, 1'b0);
      drain8();
      applyStimulus8(8'hFF, 8'h01, 1'b0);
      drain8();
      applyStimulus8(8'hFF, 8'hFF, 1'b1);
      drain8();

      // A second start issued during RUN must be ignored entirely.
      applyStimulus8(8'h05, 8'h03, 1'b0);
      repeat (2) @(negedge clk);
      a8     = 8'hAA;
      b8     = 8'h55;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      drain8();

      // Reset in RUN cycle 4: outputs drop at once and the job is dropped.
      applyStimulus8(8'h0F, 8'h0F, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      q8.delete();
      #1;
      checkOutput("abort_sum8", int'(sum8), 0);
      checkOutput("abort_cout8", int'(cout8), 0);
      checkOutput("abort_busy8", int'(busy8), 0);
      checkOutput("abort_done8", int'(done8), 0);
      @(negedge clk);

      // Release and request on the very first edge after reset.
      rst_n = 1'b1;
      applyStimulus8(8'h0F, 8'h0F, 1'b0);
      drain8();

      // Random single operations.
      for (int i = 0; i < 24; i++) begin
         r = $urandom;
         applyStimulus8(r[7:0], r[15:8], r[16]);
         drain8();
      end

      // Exhaustive N=4 run with start held high. Each operand set is held
      // until the DUT shows it was taken (busy rises), then kept until that
      // operation leaves RUN before moving on.
      start4 = 1'b1;
      for (int v = 0; v < 512 && !stalled; v++) begin
         r    = 32'(v);
         a4   = r[3:0];
         b4   = r[7:4];
         cin4 = r[8];
         q4.push_back(model4(r[3:0], r[7:4], r[8]));
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!busy4 && t < 20);
         t = 0;
         while (busy4 && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (busy4 || t >= 20) begin
            checkOutput("accept4", 0, 1);
            stalled = 1'b1;
         end
      end
      start4 = 1'b0;
      for (int i = 0; i < 40 && q4.size() != 0; i++) begin
         @(negedge clk);
      end
      repeat (8) @(negedge clk);
      checkOutput("drain4", q4.size(), 0);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
